// File: rtl/serial_7seg_rx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_7seg_rx
//  Purpose  : 8N1 UART receiver that decodes ASCII characters into four
//             active-low 7-segment patterns for a multiplexed display driver.
//             Hex characters scroll in from the right; DIGIT0 is the newest.
//  Ports    : CLK       system clock, all logic on posedge
//             RST       asynchronous, active-high reset
//             BAUD_DIV  CLK cycles per bit (>= 4, held static)
//             RXD       asynchronous serial input, idle high, LSB first
//             RX_DATA   last correctly framed byte
//             RX_VALID  1-cycle pulse per correctly framed byte
//             FERR      1-cycle pulse per framing error (stop bit low)
//             DIGIT0..3 segment patterns {dp,g,f,e,d,c,b,a}, 0 = lit
//  Revision : 1.0  initial release
// ============================================================================
module serial_7seg_rx #(
    parameter int DIV_BW = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DIV_BW-1:0] BAUD_DIV,
    input  logic              RXD,
    output logic [7:0]        RX_DATA,
    output logic              RX_VALID,
    output logic              FERR,
    output logic [7:0]        DIGIT0,
    output logic [7:0]        DIGIT1,
    output logic [7:0]        DIGIT2,
    output logic [7:0]        DIGIT3
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    localparam logic [7:0]        c_BLANK    = 8'hFF;
    localparam logic [7:0]        c_CH_SPACE = 8'h20;
    localparam logic [7:0]        c_CH_DOT   = 8'h2E;
    localparam logic [7:0]        c_CH_ESC   = 8'h1B;
    localparam logic [DIV_BW-1:0] c_ONE      = {{(DIV_BW-1){1'b0}}, 1'b1};

    // Returns {hit, pattern}; hit is set for '0'-'9', 'A'-'F', 'a'-'f'.
    function automatic logic [8:0] hex_seg(input logic [7:0] ch);
        logic [3:0] v;
        logic       hit;
        logic [7:0] pat;
        v   = 4'h0;
        hit = 1'b0;
        pat = c_BLANK;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            v   = ch[3:0];
            hit = 1'b1;
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            // low nibble of 'A'/'a' is 1, so +9 yields 10..15
            v   = ch[3:0] + 4'd9;
            hit = 1'b1;
        end
        case (v)
            4'h0: pat = 8'hC0;
            4'h1: pat = 8'hF9;
            4'h2: pat = 8'hA4;
            4'h3: pat = 8'hB0;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h92;
            4'h6: pat = 8'h82;
            4'h7: pat = 8'hF8;
            4'h8: pat = 8'h80;
            4'h9: pat = 8'h90;
            4'hA: pat = 8'h88;
            4'hB: pat = 8'h83;
            4'hC: pat = 8'hC6;
            4'hD: pat = 8'hA1;
            4'hE: pat = 8'h86;
            default: pat = 8'h8E;
        endcase
        return {hit, pat};
    endfunction

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rxs;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= RXD;
            r_rxs     <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM, output registers and digit shift register
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [DIV_BW-1:0] r_bc;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_pend_valid;   // stop bit good, publish next edge
    logic              r_pend_ferr;    // stop bit bad, flag next edge
    logic [7:0]        r_rx_data;
    logic              r_rx_valid;
    logic              r_ferr;
    logic [7:0]        r_digit0;
    logic [7:0]        r_digit1;
    logic [7:0]        r_digit2;
    logic [7:0]        r_digit3;

    logic [DIV_BW-1:0] w_half;
    logic [DIV_BW-1:0] w_last;
    logic [8:0]        w_seg;

    assign w_half = BAUD_DIV >> 1;
    assign w_last = BAUD_DIV - c_ONE;
    assign w_seg  = hex_seg(r_shift);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_bc         <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_pend_valid <= 1'b0;
            r_pend_ferr  <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_ferr       <= 1'b0;
            r_digit0     <= c_BLANK;
            r_digit1     <= c_BLANK;
            r_digit2     <= c_BLANK;
            r_digit3     <= c_BLANK;
        end else begin
            r_rx_valid   <= 1'b0;
            r_ferr       <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_ferr  <= 1'b0;

            // r_shift is stable here: a new frame cannot reach DATA
            // within one cycle of the stop-bit sample.
            if (r_pend_valid) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_shift;
                if (w_seg[8]) begin
                    r_digit3 <= r_digit2;
                    r_digit2 <= r_digit1;
                    r_digit1 <= r_digit0;
                    r_digit0 <= w_seg[7:0];
                end else if (r_shift == c_CH_SPACE) begin
                    r_digit3 <= r_digit2;
                    r_digit2 <= r_digit1;
                    r_digit1 <= r_digit0;
                    r_digit0 <= c_BLANK;
                end else if (r_shift == c_CH_DOT) begin
                    r_digit0[7] <= 1'b0;
                end else if (r_shift == c_CH_ESC) begin
                    r_digit0 <= c_BLANK;
                    r_digit1 <= c_BLANK;
                    r_digit2 <= c_BLANK;
                    r_digit3 <= c_BLANK;
                end
            end

            if (r_pend_ferr) begin
                r_ferr <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_bc <= '0;
                    if (!r_rxs) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    // mid-start-bit check rejects short low glitches
                    if (r_bc == w_half) begin
                        r_bc      <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= r_rxs ? S_IDLE : S_DATA;
                    end else begin
                        r_bc <= r_bc + c_ONE;
                    end
                end
                S_DATA: begin
                    if (r_bc == w_last) begin
                        r_bc    <= '0;
                        r_shift <= {r_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_bc <= r_bc + c_ONE;
                    end
                end
                S_STOP: begin
                    if (r_bc == w_last) begin
                        r_bc <= '0;
                        if (r_rxs) begin
                            r_state      <= S_IDLE;
                            r_pend_valid <= 1'b1;
                        end else begin
                            r_state     <= S_BREAK;
                            r_pend_ferr <= 1'b1;
                        end
                    end else begin
                        r_bc <= r_bc + c_ONE;
                    end
                end
                S_BREAK: begin
                    // a line held low produces a single FERR
                    r_bc <= '0;
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_bc    <= '0;
                end
            endcase
        end
    end

    assign RX_DATA  = r_rx_data;
    assign RX_VALID = r_rx_valid;
    assign FERR     = r_ferr;
    assign DIGIT0   = r_digit0;
    assign DIGIT1   = r_digit1;
    assign DIGIT2   = r_digit2;
    assign DIGIT3   = r_digit3;

endmodule
`default_nettype wire
